prbs_checker: RTL and testbench
===============================

Name: prbs_checker

Overview:
- Receive-side partner of the team's 32-bit Fibonacci LFSR PRNG.
- Consumes the serial bit stream produced by that generator (one new feedback bit per step) and self-synchronises by loading 32 received bits as its state.
- Once synchronised, predicts every following bit and counts mismatches; drops lock on a burst of errors.
- Sits in the PRNG test path for link/bit-error checking of generator output on the Nexys A7.

Parameters:
- LOCK_CNT, 64: consecutive correctly predicted bits needed in VERIFY before LOCKED.
- WIN, 1024: LOCKED-state error window length, in accepted bits.
- ERR_THR, 8: errors within one window that force loss of lock.
- CNT_W, 32: width of bit_count and err_count.

Ports:
- clk  in  1  system clock; all state changes on posedge.
- reset_n  in  1  asynchronous active-low reset.
- in_valid  in  1  in_bit is valid this cycle; bits are accepted only when high.
- in_bit  in  1  received stream bit (generator feedback bit, oldest first).
- clear  in  1  synchronous clear of bit_count and err_count.
- state  out  2  0=SEED, 1=VERIFY, 2=LOCKED.
- locked  out  1  high while in LOCKED.
- err_pulse  out  1  one-cycle pulse per mismatched bit while LOCKED.
- lock_lost  out  1  one-cycle pulse on the LOCKED->SEED transition.
- bit_count  out  CNT_W  bits accepted while LOCKED; saturating.
- err_count  out  CNT_W  mismatches while LOCKED; saturating.

Behaviour:
- Reset (asynchronous, reset_n=0): state=SEED, all outputs 0, S=0, all internal counters 0.
- Internal 32-bit register S[1:32]. Predicted bit e = S[32]^S[22]^S[2]^S[1]. Every shift is S <= {x, S[1:31]}.
- Nothing changes on a cycle with in_valid=0, except clear. Gaps in in_valid are transparent.
- All outputs are registered. A bit accepted at edge k is reflected in the outputs after edge k.
- SEED:
  - Shift x=in_bit.
  - Fill counter counts 0..31. On the 32nd accepted bit, go to VERIFY with the verify counter at 0.
  - If S with the new bit would be all-zero, stay in SEED and restart the fill counter (stuck stream is never valid).
- VERIFY:
  - Shift x=in_bit.
  - If in_bit==e, increment the verify counter. On the LOCK_CNT-th match, go to LOCKED and zero the window counters.
  - On a mismatch, go to SEED with the fill counter at 0.
  - No bit_count/err_count updates in VERIFY.
- LOCKED (flywheel):
  - Shift x=e, never in_bit, so one corrupted bit gives exactly one error.
  - bit_count += 1 per accepted bit.
  - On a mismatch: err_count += 1, err_pulse=1 next cycle, window error count += 1.
  - Window counter counts accepted bits. After the WIN-th bit, the window counter and window error count reset to 0.
  - When the window error count reaches ERR_THR: go to SEED, lock_lost=1 for one cycle, locked=0 the same cycle, fill counter 0. bit_count and err_count are retained.
- Simultaneous events:
  - Threshold hit on the last bit of a window: threshold wins, lock is lost.
  - clear together with an accepted bit: counters become 0 and that bit is not counted. The state machine still processes the bit, and err_pulse still fires on a mismatch.
- Counters saturate at all-ones and never wrap.
- Reset mid-operation aborts immediately to the reset values above.

Test Plan:
1. Golden model generator seeded 32'hACE10001 streams contiguously -> state 0 for bits 1-32, 1 for bits 33-96; locked=1 after the 96th valid bit; bit_count=0, err_count=0 at that point.
2. Scenario 1, then 500 more bits with bit 10 of LOCKED inverted -> exactly one err_pulse, one cycle after bit 10; err_count=1, bit_count=500, locked stays 1.
3. Scenario 1, then 8 inverted bits spaced 50 apart -> lock_lost pulse after the 8th error; state=0, locked=0, err_count=8; relock after 96 further clean bits.
4. 7 errors in window 1 plus 7 in window 2 (WIN=1024) -> no lock loss, err_count=14. Separately: mismatch at verify bit 40 -> state returns to SEED, lock delayed by exactly 72 bits.
5. Constant-zero stream for 300 valid bits -> state stays 0, locked never asserted. Scenario 1 with in_valid randomly low 50% of cycles -> identical counts and state sequence per accepted bit.
6. reset_n pulsed low for 3 cycles while LOCKED with bit_count=200 -> all outputs 0 immediately, state=0. clear asserted while LOCKED with a concurrent error -> err_count=0, bit_count=0, err_pulse=1.

Source files
------------

// File: rtl/prbs_checker_if.sv
// Stream/status bundle between a PRBS bit source and the prbs_checker.
// The master drives the received stream and clear; the slave (checker) reports lock and counts.
interface prbs_checker_if #(
   parameter int CNT_W = 32
);
   logic             in_valid;
   logic             in_bit;
   logic             clear;
   logic [1:0]       state;
   logic             locked;
   logic             err_pulse;
   logic             lock_lost;
   logic [CNT_W-1:0] bit_count;
   logic [CNT_W-1:0] err_count;

   modport master (
      output in_valid, in_bit, clear,
      input  state, locked, err_pulse, lock_lost, bit_count, err_count
   );

   modport slave (
      input  in_valid, in_bit, clear,
      output state, locked, err_pulse, lock_lost, bit_count, err_count
   );
endinterface

// File: rtl/prbs_checker.sv
// Self-synchronising checker for the 32-bit Fibonacci LFSR stream (taps 32,22,2,1).
// Seeds from 32 received bits, verifies LOCK_CNT predictions, then flywheels and counts bit errors.
module prbs_checker #(
   parameter int LOCK_CNT = 64,
   parameter int WIN      = 1024,
   parameter int ERR_THR  = 8,
   parameter int CNT_W    = 32
) (
   input  logic           clk,
   input  logic           reset_n,
   prbs_checker_if.slave  bus
);
   typedef enum logic [1:0] {SEED = 2'd0, VERIFY = 2'd1, LOCKED = 2'd2} state_e;

   localparam int VW = $clog2(LOCK_CNT + 1);
   localparam int WW = $clog2(WIN + 1);
   localparam int EW = $clog2(ERR_THR + 1);

   state_e           state_q, state_d;
   logic [1:32]      s_q, s_d;
   logic [4:0]       fill_q, fill_d;
   logic [VW-1:0]    ver_q, ver_d;
   logic [WW-1:0]    win_q, win_d;
   logic [EW-1:0]    werr_q, werr_d;
   logic [CNT_W-1:0] bits_q, bits_d, errs_q, errs_d;
   logic             locked_q, locked_d, errp_q, errp_d, lost_q, lost_d;

   logic             e, mism;
   logic [1:32]      s_in;
   logic [EW-1:0]    werr_nx;

   assign e       = s_q[32] ^ s_q[22] ^ s_q[2] ^ s_q[1];
   assign mism    = bus.in_bit ^ e;
   assign s_in    = {bus.in_bit, s_q[1:31]};
   assign werr_nx = werr_q + EW'(mism);

   always_comb begin
      state_d  = state_q;
      s_d      = s_q;
      fill_d   = fill_q;
      ver_d    = ver_q;
      win_d    = win_q;
      werr_d   = werr_q;
      bits_d   = bits_q;
      errs_d   = errs_q;
      locked_d = locked_q;
      errp_d   = 1'b0;
      lost_d   = 1'b0;
      if (bus.in_valid) begin
         case (state_q)
            SEED: begin
               s_d = s_in;
               if (fill_q == 5'd31) begin
                  fill_d = '0;
                  // an all-zero seed is the LFSR lock-up state, so it can never be a real stream
                  if (s_in != '0) begin
                     state_d = VERIFY;
                     ver_d   = '0;
                  end
               end else begin
                  fill_d = fill_q + 5'd1;
               end
            end
            VERIFY: begin
               s_d = s_in;
               if (mism) begin
                  state_d = SEED;
                  fill_d  = '0;
               end else if (ver_q == VW'(LOCK_CNT - 1)) begin
                  state_d  = LOCKED;
                  locked_d = 1'b1;
                  win_d    = '0;
                  werr_d   = '0;
               end else begin
                  ver_d = ver_q + VW'(1);
               end
            end
            LOCKED: begin
               // flywheel on the prediction so a single bad bit costs exactly one error
               s_d    = {e, s_q[1:31]};
               bits_d = (&bits_q) ? bits_q : bits_q + CNT_W'(1);
               if (mism) begin
                  errs_d = (&errs_q) ? errs_q : errs_q + CNT_W'(1);
                  errp_d = 1'b1;
               end
               if (mism && werr_nx == EW'(ERR_THR)) begin
                  state_d  = SEED;
                  locked_d = 1'b0;
                  lost_d   = 1'b1;
                  fill_d   = '0;
               end else if (win_q == WW'(WIN - 1)) begin
                  win_d  = '0;
                  werr_d = '0;
               end else begin
                  win_d  = win_q + WW'(1);
                  werr_d = werr_nx;
               end
            end
            default: begin
               state_d  = SEED;
               locked_d = 1'b0;
               fill_d   = '0;
            end
         endcase
      end
      if (bus.clear) begin
         bits_d = '0;
         errs_d = '0;
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q  <= SEED;
         s_q      <= '0;
         fill_q   <= '0;
         ver_q    <= '0;
         win_q    <= '0;
         werr_q   <= '0;
         bits_q   <= '0;
         errs_q   <= '0;
         locked_q <= 1'b0;
         errp_q   <= 1'b0;
         lost_q   <= 1'b0;
      end else begin
         state_q  <= state_d;
         s_q      <= s_d;
         fill_q   <= fill_d;
         ver_q    <= ver_d;
         win_q    <= win_d;
         werr_q   <= werr_d;
         bits_q   <= bits_d;
         errs_q   <= errs_d;
         locked_q <= locked_d;
         errp_q   <= errp_d;
         lost_q   <= lost_d;
      end
   end

   assign bus.state     = state_q;
   assign bus.locked    = locked_q;
   assign bus.err_pulse = errp_q;
   assign bus.lock_lost = lost_q;
   assign bus.bit_count = bits_q;
   assign bus.err_count = errs_q;
endmodule

// File: tb/tb_prbs_checker.sv
// Scoreboarded bench for prbs_checker: a stream-history reference model predicts every cycle,
// a monitor compares each registered output set, and directed checks pin the headline numbers.
module tb_prbs_checker;
   localparam int LOCK_CNT = 64;
   localparam int WIN      = 1024;
   localparam int ERR_THR  = 8;

   logic clk = 1'b0;
   logic reset_n = 1'b0;
   always #5 clk = ~clk;

   prbs_checker_if #(.CNT_W(32)) bus ();

   prbs_checker #(.LOCK_CNT(LOCK_CNT), .WIN(WIN), .ERR_THR(ERR_THR), .CNT_W(32)) dut (
      .clk     (clk),
      .reset_n (reset_n),
      .bus     (bus.slave)
   );

   typedef struct {
      logic [1:0]  st;
      logic        lk;
      logic        ep;
      logic        ll;
      logic [31:0] bc;
      logic [31:0] ec;
   } exp_t;

   exp_t        exp_q[$];
   int          n_cmp = 0;
   int          n_bad = 0;
   int          pulse_cnt = 0;
   logic [31:0] gen;

   // reference model: last 32 believed stream bits, oldest at index 0
   bit     hist[$];
   int     m_mode, m_fill, m_run, m_wpos, m_werr;
   longint m_bits, m_errs;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] want);
      n_cmp++;
      if (act !== want) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h at %0t", nm, act, want, $time);
      end
   endtask

   task automatic model_reset();
      hist.delete();
      for (int i = 0; i < 32; i++) hist.push_back(1'b0);
      m_mode = 0; m_fill = 0; m_run = 0; m_wpos = 0; m_werr = 0;
      m_bits = 0; m_errs = 0;
   endtask

   task automatic push_hist(input bit b);
      hist.push_back(b);
      void'(hist.pop_front());
   endtask

   task automatic model_step(input bit v, input bit b, input bit c);
      bit   p, ep, ll, any;
      exp_t x;
      ep = 1'b0; ll = 1'b0;
      p  = hist[0] ^ hist[10] ^ hist[30] ^ hist[31];
      if (v) begin
         if (m_mode == 0) begin
            push_hist(b);
            m_fill++;
            if (m_fill == 32) begin
               m_fill = 0;
               any = 1'b0;
               foreach (hist[i]) any |= hist[i];
               if (any) begin m_mode = 1; m_run = 0; end
            end
         end else if (m_mode == 1) begin
            push_hist(b);
            if (b != p) begin m_mode = 0; m_fill = 0; end
            else begin
               m_run++;
               if (m_run == LOCK_CNT) begin m_mode = 2; m_wpos = 0; m_werr = 0; end
            end
         end else begin
            push_hist(p);
            if (m_bits < 64'hFFFF_FFFF) m_bits++;
            if (b != p) begin
               if (m_errs < 64'hFFFF_FFFF) m_errs++;
               ep = 1'b1;
               m_werr++;
            end
            m_wpos++;
            if (m_werr == ERR_THR) begin m_mode = 0; ll = 1'b1; m_fill = 0; end
            else if (m_wpos == WIN) begin m_wpos = 0; m_werr = 0; end
         end
      end
      if (c) begin m_bits = 0; m_errs = 0; end
      x.st = 2'(m_mode); x.lk = (m_mode == 2); x.ep = ep; x.ll = ll;
      x.bc = m_bits[31:0]; x.ec = m_errs[31:0];
      exp_q.push_back(x);
   endtask

   task automatic drive(input bit v, input bit b, input bit c);
      @(posedge clk);
      #2;
      bus.in_valid = v; bus.in_bit = b; bus.clear = c;
      model_step(v, b, c);
   endtask

   task automatic idle();
      drive(1'b0, 1'b0, 1'b0);
   endtask

   task automatic gen_bit(output bit f);
      f   = gen[31] ^ gen[21] ^ gen[1] ^ gen[0];
      gen = {gen[30:0], f};
   endtask

   task automatic send(input bit inv, input bit clr);
      bit b;
      gen_bit(b);
      drive(1'b1, b ^ inv, clr);
   endtask

   task automatic check_zero(input string nm);
      chk({nm, "_state"}, 32'(bus.state), 32'd0);
      chk({nm, "_locked"}, 32'(bus.locked), 32'd0);
      chk({nm, "_err_pulse"}, 32'(bus.err_pulse), 32'd0);
      chk({nm, "_lock_lost"}, 32'(bus.lock_lost), 32'd0);
      chk({nm, "_bit_count"}, bus.bit_count, 32'd0);
      chk({nm, "_err_count"}, bus.err_count, 32'd0);
   endtask

   task automatic do_reset();
      @(posedge clk);
      #2;
      reset_n = 1'b0;
      bus.in_valid = 1'b0; bus.in_bit = 1'b0; bus.clear = 1'b0;
      exp_q.delete();
      model_reset();
      #1;
      check_zero("rst");
      repeat (3) @(posedge clk);
      #2 reset_n = 1'b1;
   endtask

   initial begin : monitor
      exp_t x;
      forever begin
         @(posedge clk);
         #1;
         if (bus.err_pulse === 1'b1) pulse_cnt++;
         if (exp_q.size() > 0) begin
            x = exp_q.pop_front();
            chk("sb_state", 32'(bus.state), 32'(x.st));
            chk("sb_locked", 32'(bus.locked), 32'(x.lk));
            chk("sb_err_pulse", 32'(bus.err_pulse), 32'(x.ep));
            chk("sb_lock_lost", 32'(bus.lock_lost), 32'(x.ll));
            chk("sb_bit_count", bus.bit_count, x.bc);
            chk("sb_err_count", bus.err_count, x.ec);
         end
      end
   end

   initial begin : watchdog
      #2_000_000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog expired");
   end

   initial begin : stim
      int  p0;
      bit  b;
      bus.in_valid = 1'b0; bus.in_bit = 1'b0; bus.clear = 1'b0;
      model_reset();
      #1;
      check_zero("por");
      repeat (2) @(posedge clk);
      #2 reset_n = 1'b1;

      // golden seed: VERIFY after 32 bits, LOCKED after 96
      gen = 32'hACE10001;
      repeat (96) send(1'b0, 1'b0);
      idle();
      chk("sc1_locked", 32'(bus.locked), 32'd1);
      chk("sc1_bit_count", bus.bit_count, 32'd0);
      chk("sc1_err_count", bus.err_count, 32'd0);

      // one corrupted bit while locked
      p0 = pulse_cnt;
      for (int i = 1; i <= 500; i++) send(i == 10, 1'b0);
      idle();
      chk("sc2_err_count", bus.err_count, 32'd1);
      chk("sc2_bit_count", bus.bit_count, 32'd500);
      chk("sc2_locked", 32'(bus.locked), 32'd1);
      chk("sc2_pulses", 32'(pulse_cnt - p0), 32'd1);

      // eight errors 50 apart lose lock, then relock
      do_reset();
      gen = 32'hACE10001;
      repeat (96) send(1'b0, 1'b0);
      for (int i = 1; i <= 360; i++) send(i % 50 == 10, 1'b0);
      idle();
      chk("sc3_state", 32'(bus.state), 32'd0);
      chk("sc3_locked", 32'(bus.locked), 32'd0);
      chk("sc3_lock_lost", 32'(bus.lock_lost), 32'd1);
      chk("sc3_err_count", bus.err_count, 32'd8);
      repeat (96) send(1'b0, 1'b0);
      idle();
      chk("sc3_relock", 32'(bus.locked), 32'd1);

      // 7 + 7 errors split across two windows keep lock
      do_reset();
      gen = 32'hACE10001;
      repeat (96) send(1'b0, 1'b0);
      for (int i = 1; i <= 1800; i++)
         send((i % 100 == 0) && (i <= 700 || (i >= 1100 && i <= 1700)), 1'b0);
      idle();
      chk("sc4_err_count", bus.err_count, 32'd14);
      chk("sc4_locked", 32'(bus.locked), 32'd1);
      chk("sc4_bit_count", bus.bit_count, 32'd1800);

      // mismatch at verify bit 40 delays lock by 72 bits
      do_reset();
      gen = 32'hACE10001;
      for (int i = 1; i <= 167; i++) send(i == 72, 1'b0);
      idle();
      chk("sc4b_not_yet", 32'(bus.locked), 32'd0);
      send(1'b0, 1'b0);
      idle();
      chk("sc4b_locked", 32'(bus.locked), 32'd1);

      // stuck-at-zero stream never leaves SEED
      do_reset();
      repeat (300) drive(1'b1, 1'b0, 1'b0);
      idle();
      chk("sc5_state", 32'(bus.state), 32'd0);

      // gaps in in_valid are transparent
      do_reset();
      gen = 32'hACE10001;
      for (int i = 0; i < 96; i++) begin
         while ($urandom_range(0, 1) == 1) idle();
         send(1'b0, 1'b0);
      end
      idle();
      chk("sc5b_locked", 32'(bus.locked), 32'd1);
      chk("sc5b_bit_count", bus.bit_count, 32'd0);

      // async reset while locked, then clear with a concurrent error
      do_reset();
      gen = 32'hACE10001;
      repeat (296) send(1'b0, 1'b0);
      idle();
      chk("sc6_bit_count", bus.bit_count, 32'd200);
      do_reset();
      repeat (101) send(1'b0, 1'b0);
      gen_bit(b);
      drive(1'b1, ~b, 1'b1);
      idle();
      chk("sc6_clr_err_count", bus.err_count, 32'd0);
      chk("sc6_clr_bit_count", bus.bit_count, 32'd0);
      chk("sc6_clr_err_pulse", 32'(bus.err_pulse), 32'd1);

      // random mix of gaps, errors and clears against the model
      do_reset();
      gen = $urandom() | 32'd1;
      for (int i = 0; i < 3000; i++) begin
         if ($urandom_range(0, 99) < 25) drive(1'b0, 1'($urandom_range(0, 1)), $urandom_range(0, 299) == 0);
         else send($urandom_range(0, 199) == 0, $urandom_range(0, 299) == 0);
      end
      repeat (3) idle();
      @(posedge clk);
      #3;
      chk("sb_drained", 32'(exp_q.size()), 32'd0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule
